// File: rtl/router_in_port_pkg.sv
// Shared types for the router input port: packet layout, assembly
// states and packet size in bytes.
package router_in_port_pkg;

  localparam int BYTES_PER_PKT = 4;

  // Wire order is src/dest first, then data MSB to LSB, so the packed
  // layout matches the byte stream read top-down.
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  // Which byte of the packet is expected next.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } byte_idx_e;

endpackage

// File: rtl/router_in_port_pkt_fifo.sv
// Packet FIFO: combinational head read, registered push/pop.
// A pop frees a slot on the same edge, so push+pop is accepted even when full.
// A push into a full FIFO without a pop is dropped and flagged on overflow.
module pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign head     = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks net push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Router input port: reassembles the node's byte stream into 4-byte
// packets, queues them, and offers the head to output arbitration.
// Optional mid-packet idle timeout enabled by defining PKT_TIMEOUT_EN.
module router_in_port
  import router_in_port_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   free_inbound,
  input  logic                   put_inbound,
  input  logic [7:0]             payload_inbound,
  output logic [31:0]            pkt_out,
  output logic                   pkt_valid,
  input  logic                   pkt_grant,
  output logic                   proto_err,
  output logic [$clog2(DEPTH):0] occupancy
);

  byte_idx_e   state;
  logic [23:0] hdr;        // bytes 0..2 shifted in, byte0 ends up on top
  pkt_t        push_pkt;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_ovf;
  logic        abort;

  assign free_inbound = !reset && (state == IDLE) && !fifo_full;
  assign push_pkt     = {hdr, payload_inbound};
  assign push         = (state == B3) && put_inbound && !abort;
  assign pop          = pkt_valid && pkt_grant;
  assign pkt_valid    = !fifo_empty;

`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  assign abort = (state != IDLE) && (idle_cnt == TW'(TIMEOUT));

  // Consecutive stall cycles inside a packet; cleared by any byte or IDLE.
  always_ff @(posedge clock) begin
    if (reset || state == IDLE || abort || put_inbound) idle_cnt <= '0;
    else                                                idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  // Assembly FSM: shift bytes in, push on byte3, flag drops and aborts.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      hdr       <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= abort || fifo_ovf || (state == IDLE && put_inbound && !free_inbound);
      if (abort) begin
        state <= IDLE;
      end else if (put_inbound) begin
        case (state)
          IDLE: if (free_inbound) begin
                  hdr   <= {hdr[15:0], payload_inbound};
                  state <= B1;
                end
          B1:   begin hdr <= {hdr[15:0], payload_inbound}; state <= B2; end
          B2:   begin hdr <= {hdr[15:0], payload_inbound}; state <= B3; end
          B3:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  pkt_fifo #(
    .WIDTH ($bits(pkt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .head      (pkt_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .count     (occupancy)
  );

  // byte0 is gated by free, so a full-FIFO push means the FSM went wrong.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !fifo_ovf);
  a_params: assert property (@(posedge clock)
    (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (TIMEOUT >= 1) && (BYTES_PER_PKT == 4));

endmodule
